// File: rtl/simd_alu_ctrl_if.sv
// Bundle of command, memory, ALU, debug and status signals for simd_alu_ctrl.
// slave is the controller side; master is the environment side.
interface simd_alu_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned DATA_W = 512;
  localparam int unsigned RES_W  = 1024;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_reg;
  logic [ADDR_W-1:0] cmd_addr;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [RES_W-1:0]  alu_result;

  logic [1:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_addr,
    input  mem_rdata, mem_ack, alu_result, dbg_sel,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output alu_op, alu_a, alu_b, dbg_data, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_addr,
    output mem_rdata, mem_ack, alu_result, dbg_sel,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  alu_op, alu_a, alu_b, dbg_data, busy, done, err
  );
endinterface

// File: rtl/simd_alu_ctrl.sv
// Four-register 512-bit SIMD controller: load/store via a req/ack memory port, add/mul via an external ALU.
// Optional memory-ack watchdog enabled by defining SIMD_ALU_CTRL_TIMEOUT_EN.
module simd_alu_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  simd_alu_ctrl_if.slave bus
);
  localparam int unsigned DATA_W = 512;
  localparam int unsigned NREG   = 4;
  localparam logic [1:0]  OP_STORE = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a_q [NREG];
  logic [1:0]        reg_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        alu_op_q;
  logic              done_q;

`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

  // Controller FSM and register file; op[1] selects the ALU path, op[0] load vs store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      for (int i = 0; i < NREG; i++) a_q[i] <= '0;
      reg_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      alu_op_q    <= 2'b00;
      done_q      <= 1'b0;
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            reg_q <= bus.cmd_reg;
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            if (bus.cmd_op[1]) begin
              alu_op_q <= bus.cmd_op;
              state    <= S_EXEC;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= (bus.cmd_op == OP_STORE);
              mem_addr_q <= bus.cmd_addr;
              if (bus.cmd_op == OP_STORE) mem_wdata_q <= a_q[bus.cmd_reg];
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
              to_cnt     <= '0;
`endif
              state      <= S_MEM;
            end
          end
        end
        S_EXEC: begin
          a_q[2]   <= bus.alu_result[511:0];
          a_q[3]   <= bus.alu_result[1023:512];
          alu_op_q <= 2'b00;
          done_q   <= 1'b1;
          state    <= S_DONE;
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (!mem_we_q) a_q[reg_q] <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
          // Abort on the TIMEOUT_CYC-th unacknowledged cycle.
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = a_q[0];
  assign bus.alu_b     = a_q[1];
  assign bus.dbg_data  = a_q[bus.dbg_sel];
  assign bus.done      = done_q;
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_simd_alu_ctrl.sv
// Directed self-checking bench for simd_alu_ctrl, with a signed 16-lane reference ALU.
// Covers the watchdog path when SIMD_ALU_CTRL_TIMEOUT_EN is defined.
module tb_simd_alu_ctrl;
  localparam int unsigned ADDR_W = 8;

  localparam logic [511:0] V5    = {16{32'h0000_0005}};
  localparam logic [511:0] V7    = {16{32'h0000_0007}};
  localparam logic [511:0] VSUM  = {8{64'h0000_0000_0000_000C}};
  localparam logic [511:0] VNEG  = {16{32'h8000_0000}};
  localparam logic [511:0] V2    = {16{32'h0000_0002}};
  localparam logic [511:0] VPROD = {8{64'hFFFF_FFFF_0000_0000}};
  localparam logic [511:0] VP    = {16{32'h1234_5678}};
  localparam logic [511:0] VQ    = {16{32'hCAFE_0001}};
  localparam logic [511:0] VJUNK = {16{32'hBAD0_BAD0}};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned cnt;

  simd_alu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  simd_alu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ALU: signed 32-bit lanes widened to 64-bit results; junk when idle.
  logic [1023:0]      alu_res;
  logic signed [63:0] ea, eb;
  always_comb begin
    alu_res = {16{64'hA5A5_5A5A_DEAD_BEEF}};
    ea = '0;
    eb = '0;
    for (int i = 0; i < 16; i++) begin
      ea = {{32{bus.alu_a[i*32+31]}}, bus.alu_a[i*32 +: 32]};
      eb = {{32{bus.alu_b[i*32+31]}}, bus.alu_b[i*32 +: 32]};
      if (bus.alu_op == 2'b10)      alu_res[i*64 +: 64] = ea + eb;
      else if (bus.alu_op == 2'b11) alu_res[i*64 +: 64] = ea * eb;
    end
  end
  assign bus.alu_result = alu_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [511:0] exp);
    bus.dbg_sel = sel;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [7:0] addr);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_reg   = r;
    bus.cmd_addr  = addr;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [7:0] addr, input logic [511:0] data);
    issue(2'b01, r, addr);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = VJUNK;
    tick();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_reg   = 2'b00;
    bus.cmd_addr  = '0;
    bus.mem_rdata = VJUNK;
    bus.mem_ack   = 1'b0;
    bus.dbg_sel   = 2'b00;
    cnt           = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_alu_op", bus.alu_op, 2'b00);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    for (int s = 0; s < 4; s++) chk_reg("rst_areg", 2'(s), '0);
    rst_n = 1'b1;
    tick();

    // Load A1 with ack in the first MEM cycle
    issue(2'b01, 2'd0, 8'h20);
    chk("ld1_req", bus.mem_req, 1'b1);
    chk("ld1_we", bus.mem_we, 1'b0);
    chk("ld1_addr", bus.mem_addr, 8'h20);
    chk("ld1_ready", bus.cmd_ready, 1'b0);
    chk("ld1_busy", bus.busy, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = V5;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = VJUNK;
    chk("ld1_done", bus.done, 1'b1);
    chk("ld1_req_drop", bus.mem_req, 1'b0);
    chk_reg("ld1_a1", 2'd0, V5);
    tick();
    chk("ld1_done_end", bus.done, 1'b0);
    chk("ld1_ready_back", bus.cmd_ready, 1'b1);

    // Load A2 with one wait cycle
    issue(2'b01, 2'd1, 8'h21);
    tick();
    chk("ld2_req_wait", bus.mem_req, 1'b1);
    chk("ld2_nodone", bus.done, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = V7;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = VJUNK;
    chk("ld2_done", bus.done, 1'b1);
    tick();
    chk_reg("ld2_a2", 2'd1, V7);

    // Add: done in cycle N+2, ready in N+3
    issue(2'b10, 2'd0, 8'h00);
    chk("add_alu_op", bus.alu_op, 2'b10);
    chk("add_alu_a", bus.alu_a, V5);
    chk("add_alu_b", bus.alu_b, V7);
    chk("add_exec_nodone", bus.done, 1'b0);
    tick();
    chk("add_done", bus.done, 1'b1);
    chk("add_done_ready", bus.cmd_ready, 1'b0);
    chk("add_alu_op_idle", bus.alu_op, 2'b00);
    chk_reg("add_a3", 2'd2, VSUM);
    chk_reg("add_a4", 2'd3, VSUM);
    tick();
    chk("add_ready", bus.cmd_ready, 1'b1);
    chk("add_done_once", bus.done, 1'b0);

    // Stray ack while idle must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = VJUNK;
    tick();
    bus.mem_ack   = 1'b0;
    chk("stray_ack_ready", bus.cmd_ready, 1'b1);
    chk("stray_ack_done", bus.done, 1'b0);
    chk_reg("stray_ack_a1", 2'd0, V5);

    // Signed multiply
    load_reg(2'd0, 8'h22, VNEG);
    load_reg(2'd1, 8'h23, V2);
    issue(2'b11, 2'd0, 8'h00);
    chk("mul_alu_op", bus.alu_op, 2'b11);
    tick();
    chk("mul_done", bus.done, 1'b1);
    chk_reg("mul_a3", 2'd2, VPROD);
    chk_reg("mul_a4", 2'd3, VPROD);
    tick();

    // Store A3 to 0x10 with ack in the fourth request cycle
    issue(2'b00, 2'd2, 8'h10);
    for (int k = 0; k < 4; k++) begin
      chk("st_req", bus.mem_req, 1'b1);
      chk("st_we", bus.mem_we, 1'b1);
      chk("st_addr", bus.mem_addr, 8'h10);
      chk("st_wdata", bus.mem_wdata, VPROD);
      chk("st_nodone", bus.done, 1'b0);
      if (k == 3) bus.mem_ack = 1'b1;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("st_done", bus.done, 1'b1);
    chk("st_req_drop", bus.mem_req, 1'b0);
    chk_reg("st_a3_kept", 2'd2, VPROD);
    tick();
    chk("st_ready", bus.cmd_ready, 1'b1);

    // cmd_valid held high across a whole load
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_reg   = 2'd3;
    bus.cmd_addr  = 8'h30;
    tick();
    chk("hold_addr", bus.mem_addr, 8'h30);
    chk("hold_we", bus.mem_we, 1'b0);
    tick();
    chk("hold_req", bus.mem_req, 1'b1);
    chk("hold_ready_mem", bus.cmd_ready, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = VP;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 8'h40;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = VJUNK;
    chk("hold_done", bus.done, 1'b1);
    chk("hold_ready_done", bus.cmd_ready, 1'b0);
    chk("hold_addr_stable", bus.mem_addr, 8'h30);
    tick();
    chk("hold_idle_ready", bus.cmd_ready, 1'b1);
    chk("hold_idle_noreq", bus.mem_req, 1'b0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("hold_next_req", bus.mem_req, 1'b1);
    chk("hold_next_we", bus.mem_we, 1'b1);
    chk("hold_next_addr", bus.mem_addr, 8'h40);
    chk("hold_next_wdata", bus.mem_wdata, VP);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();

    // Reset two cycles into MEM aborts the load
    issue(2'b01, 2'd0, 8'h50);
    tick();
    chk("rstmid_req_before", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", bus.mem_req, 1'b0);
    chk("rstmid_ready", bus.cmd_ready, 1'b1);
    chk("rstmid_busy", bus.busy, 1'b0);
    for (int s = 0; s < 4; s++) chk_reg("rstmid_areg", 2'(s), '0);
    tick();
    chk("rstmid_nodone", bus.done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_nodone_after", bus.done, 1'b0);
    chk("rstmid_ready_after", bus.cmd_ready, 1'b1);

    // Load with no ack: watchdog abort or indefinite wait
    load_reg(2'd0, 8'h60, VQ);
    issue(2'b01, 2'd0, 8'h61);
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
`ifdef SIMD_ALU_CTRL_TIMEOUT_EN
    chk("to_mem_cycles", cnt, 255);
    chk("to_done", bus.done, 1'b1);
    chk("to_err", bus.err, 1'b1);
    chk("to_req", bus.mem_req, 1'b0);
    tick();
    chk_reg("to_a1_kept", 2'd0, VQ);
    chk("to_err_sticky", bus.err, 1'b1);
    chk("to_ready", bus.cmd_ready, 1'b1);
`else
    chk("wait_mem_cycles", cnt, 400);
    chk("wait_err", bus.err, 1'b0);
    chk("wait_req", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = VP;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = VJUNK;
    chk("wait_done", bus.done, 1'b1);
    tick();
    chk_reg("wait_a1", 2'd0, VP);
`endif

    // A new command clears err
    issue(2'b10, 2'd0, 8'h00);
    chk("err_clear", bus.err, 1'b0);
    tick();
    chk("final_done", bus.done, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/simd_alu_ctrl.md
SIMD_ALU_CTRL -- requirements
Module: simd_alu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, sets the memory word-address width.
REQ-002 Parameter TIMEOUT_CYC, default 255, sets the memory-ack watchdog limit in cycles; it is used only when SIMD_ALU_CTRL_TIMEOUT_EN is defined.
REQ-003 clk  in  1  Sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  Asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  Command offered.
REQ-006 cmd_ready  out  1  Controller idle and able to accept a command.
REQ-007 cmd_op  in  2  Opcode: 00 store, 01 load, 10 add, 11 multiply.
REQ-008 cmd_reg  in  2  Register index A1..A4 (encoded 0..3), used by load/store only.
REQ-009 cmd_addr  in  ADDR_W  Memory word address, used by load/store only.
REQ-010 mem_req  out  1  Memory request, held until acknowledged.
REQ-011 mem_we  out  1  1 = write (store), 0 = read (load).
REQ-012 mem_addr  out  ADDR_W  Memory address.
REQ-013 mem_wdata  out  512  Store data.
REQ-014 mem_rdata  in  512  Load data, valid when mem_ack = 1.
REQ-015 mem_ack  in  1  Memory completion strobe.
REQ-016 alu_op  out  2  Operation code driven to the 16-lane ALU.
REQ-017 alu_a, alu_b  out  512 each  ALU operands: alu_a is A1, alu_b is A2, continuously.
REQ-018 alu_result  in  1024  Combinational ALU result, 16 lanes of 64 bits each.
REQ-019 dbg_sel  in  2; dbg_data  out  512  Combinational read-out of register A[dbg_sel].
REQ-020 busy  out  1; done  out  1; err  out  1  Status outputs.

Function
REQ-021 The controller SHALL contain four 512-bit registers A1..A4 and an FSM with states IDLE, MEM, EXEC and DONE.
REQ-022 cmd_ready SHALL equal 1 only in IDLE, and busy SHALL equal NOT cmd_ready.
REQ-023 A command SHALL be accepted on a clock edge where cmd_valid & cmd_ready; op, reg and addr are latched at acceptance, and the inputs are ignored at all other times.
REQ-024 Accepting add (10) or multiply (11) SHALL move the FSM IDLE->EXEC.
REQ-025 In EXEC, alu_op SHALL equal the latched op; at the end of that cycle A3 <= alu_result[511:0] and A4 <= alu_result[1023:512]; the FSM then moves to DONE.
REQ-026 Accepting load or store SHALL move the FSM IDLE->MEM, with mem_req=1, mem_addr=latched addr, and mem_we=1 for store / 0 for load, all registered.
REQ-027 For a store, mem_wdata SHALL hold A[cmd_reg] as captured at acceptance.
REQ-028 In MEM, mem_req and all mem_* outputs SHALL remain stable until a cycle with mem_ack=1; on that edge a load writes mem_rdata into A[reg], mem_req drops to 0, and the FSM moves to DONE.
REQ-029 An ack arriving in the same cycle mem_req first rises SHALL complete the access.
REQ-030 mem_ack outside MEM SHALL be ignored.
REQ-031 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-032 Add/multiply latency SHALL be: accept at edge N, done high in cycle N+2, cmd_ready high in cycle N+3.
REQ-033 Outside EXEC, alu_op SHALL be 2'b00, and alu_result SHALL be ignored.
REQ-034 err SHALL be sticky; it is cleared only by reset or by acceptance of a new command.

Reset
REQ-035 While rst_n=0 (asynchronously): FSM=IDLE, A1..A4=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_op=00, done=0, err=0, so cmd_ready=1 and busy=0.
REQ-036 Reset asserted mid-operation SHALL abort it: no register write occurs, mem_req deasserts immediately, and done does not pulse.

Configuration
REQ-037 With SIMD_ALU_CTRL_TIMEOUT_EN defined, a counter cleared on entry to MEM increments each MEM cycle without mem_ack; reaching TIMEOUT_CYC aborts the access (mem_req=0, no register write), sets err=1, and moves the FSM to DONE.
REQ-038 Without SIMD_ALU_CTRL_TIMEOUT_EN, no counter exists, MEM waits indefinitely, and err is tied to 0.

Verification
REQ-039 Load A1 then A2 with every lane = 0x00000005 and 0x00000007, then add: each 64-bit lane of {A4,A3} = 0x000000000000000C; done pulses two cycles after the add is accepted.
REQ-040 Multiply with lanes 0x80000000 x 0x00000002: each lane = 0xFFFFFFFF00000000; the result appears in A3/A4 via dbg_data.
REQ-041 Store A3 to address 0x10 with mem_ack delayed 3 cycles: mem_req is held 4 cycles with stable addr/wdata, and done follows the ack by one cycle.
REQ-042 Hold cmd_valid high throughout a load: exactly one command is accepted, and the next one is accepted only in the cycle after done.
REQ-043 Deassert rst_n two cycles into MEM: mem_req=0 immediately, A1..A4 are zero, and no done pulse occurs.
REQ-044 With SIMD_ALU_CTRL_TIMEOUT_EN and no ack: err=1 and done pulses after exactly 255 MEM cycles, and the target register is unchanged.
